// File: rtl/pair_batch_issuer.sv
// pair_batch_issuer
//   Stores a set of points and walks every unordered pair (u < v) exactly once.
//   Each output beat carries one reference point u plus up to BATCH_SIZE
//   candidate points v, v+1, ... as parallel lanes.
// Ports
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   load_valid/point : append a point at index num_points (IDLE only)
//   load_ready       : store can take a write this cycle
//   clear            : IDLE only, empties the store (wins over a same-cycle load)
//   start            : IDLE only, begin a pair enumeration run
//   num_points       : points currently held
//   busy             : a run is in progress (ISSUE or DONE)
//   done             : single-cycle pulse when a run finishes
//   out_valid/ready  : beat handshake towards the consumer
//   reference_point/_index : point u of the current beat
//   coords/out_indices/lane_valid : per-lane candidate v+i, zeroed on invalid lanes
module pair_batch_issuer #(
  parameter int INDEX_BIT_WIDTH = 32,
  parameter int COORD_BIT_WIDTH = 12,
  parameter int DIMENSIONS      = 3,
  parameter int BATCH_SIZE      = 16,
  parameter int MAX_POINTS      = 1024,
  parameter int CNT_W           = $clog2(MAX_POINTS + 1)
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic                                                        load_valid,
  input  logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]                  load_point,
  output logic                                                        load_ready,
  input  logic                                                        clear,
  input  logic                                                        start,
  output logic [CNT_W-1:0]                                            num_points,
  output logic                                                        busy,
  output logic                                                        done,
  output logic                                                        out_valid,
  input  logic                                                        out_ready,
  output logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]                  reference_point,
  output logic [INDEX_BIT_WIDTH-1:0]                                  reference_index,
  output logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]  coords,
  output logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0]                  out_indices,
  output logic [BATCH_SIZE-1:0]                                       lane_valid
);

  localparam int AW = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
  // Lane index v+i can run past MAX_POINTS by up to BATCH_SIZE.
  localparam int IW = $clog2(MAX_POINTS + BATCH_SIZE + 1);

  typedef logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] point_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2} state_t;

  point_t r_mem [MAX_POINTS];

  state_t                                      r_state;
  logic [CNT_W-1:0]                            r_u;
  logic [CNT_W-1:0]                            r_v;
  logic [CNT_W-1:0]                            r_num_points;
  logic                                        r_load_ready;
  logic                                        r_out_valid;
  logic                                        r_done;
  logic                                        r_busy;
  point_t                                      r_ref_point;
  logic [INDEX_BIT_WIDTH-1:0]                  r_ref_index;
  logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] r_coords;
  logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0]  r_indices;
  logic [BATCH_SIZE-1:0]                       r_lane_valid;

  state_t                                      w_state_nxt;
  logic [CNT_W-1:0]                            w_u_nxt;
  logic [CNT_W-1:0]                            w_v_nxt;
  logic [CNT_W-1:0]                            w_num_nxt;
  logic                                        w_out_valid_nxt;
  logic                                        w_done_nxt;
  logic                                        w_beat_load;
  logic                                        w_load_fire;
  logic                                        w_clear_fire;
  point_t                                      w_ref_point;
  logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] w_coords;
  logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0]  w_indices;
  logic [BATCH_SIZE-1:0]                       w_lane_valid;
  logic [IW-1:0]                               w_lane_idx [BATCH_SIZE];

  assign load_ready      = r_load_ready;
  assign num_points      = r_num_points;
  assign busy            = r_busy;
  assign done            = r_done;
  assign out_valid       = r_out_valid;
  assign reference_point = r_ref_point;
  assign reference_index = r_ref_index;
  assign coords          = r_coords;
  assign out_indices     = r_indices;
  assign lane_valid      = r_lane_valid;

  // Load/clear acceptance and the point count as seen by a same-cycle start.
  always_comb begin
    w_clear_fire = (r_state == S_IDLE) && clear;
    w_load_fire  = load_valid && r_load_ready && !w_clear_fire;
    if (w_clear_fire) begin
      w_num_nxt = '0;
    end else if (w_load_fire) begin
      w_num_nxt = r_num_points + CNT_W'(1);
    end else begin
      w_num_nxt = r_num_points;
    end
  end

  // Enumeration FSM: next state, next (u, v) cursor and beat-load strobe.
  always_comb begin
    w_state_nxt     = r_state;
    w_u_nxt         = r_u;
    w_v_nxt         = r_v;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;
    w_beat_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (w_num_nxt < CNT_W'(2))) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (start) begin
          w_state_nxt     = S_ISSUE;
          w_u_nxt         = '0;
          w_v_nxt         = CNT_W'(1);
          w_out_valid_nxt = 1'b1;
          w_beat_load     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_out_valid && out_ready) begin
          // Stay on this u while more candidates remain, else move to u+1.
          if ((IW'(r_v) + IW'(BATCH_SIZE)) < IW'(r_num_points)) begin
            w_v_nxt = r_v + CNT_W'(BATCH_SIZE);
          end else begin
            w_u_nxt = r_u + CNT_W'(1);
            w_v_nxt = r_u + CNT_W'(2);
          end
          // The last point has no partner with a higher index: run is over.
          if (w_u_nxt == (r_num_points - CNT_W'(1))) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_DONE;
            w_done_nxt      = 1'b1;
          end else begin
            w_beat_load = 1'b1;
          end
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Next beat contents, with a bypass for a point written on the start edge.
  always_comb begin
    w_ref_point  = '0;
    w_coords     = '0;
    w_indices    = '0;
    w_lane_valid = '0;
    if (w_load_fire && (w_u_nxt == r_num_points)) begin
      w_ref_point = load_point;
    end else begin
      w_ref_point = r_mem[w_u_nxt[AW-1:0]];
    end
    for (int i = 0; i < BATCH_SIZE; i++) begin
      w_lane_idx[i] = IW'(w_v_nxt) + IW'(i);
      if (w_lane_idx[i] < IW'(w_num_nxt)) begin
        w_lane_valid[i] = 1'b1;
        w_indices[i]    = INDEX_BIT_WIDTH'(w_lane_idx[i]);
        if (w_load_fire && (w_lane_idx[i] == IW'(r_num_points))) begin
          w_coords[i] = load_point;
        end else begin
          w_coords[i] = r_mem[w_lane_idx[i][AW-1:0]];
        end
      end else begin
        w_lane_valid[i] = 1'b0;
        w_indices[i]    = '0;
        w_coords[i]     = '0;
      end
    end
  end

  // Point store write port; contents are intentionally kept across reset.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_mem[r_num_points[AW-1:0]] <= load_point;
    end
  end

  // Control, status and beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_u          <= '0;
      r_v          <= '0;
      r_num_points <= '0;
      r_load_ready <= 1'b1;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_ref_point  <= '0;
      r_ref_index  <= '0;
      r_coords     <= '0;
      r_indices    <= '0;
      r_lane_valid <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_u          <= w_u_nxt;
      r_v          <= w_v_nxt;
      r_num_points <= w_num_nxt;
      r_load_ready <= (w_state_nxt == S_IDLE) && (w_num_nxt < CNT_W'(MAX_POINTS));
      r_out_valid  <= w_out_valid_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_beat_load) begin
        r_ref_point  <= w_ref_point;
        r_ref_index  <= INDEX_BIT_WIDTH'(w_u_nxt);
        r_coords     <= w_coords;
        r_indices    <= w_indices;
        r_lane_valid <= w_lane_valid;
      end
    end
  end

endmodule

// File: tb/tb_pair_batch_issuer.sv
// Self-checking bench for pair_batch_issuer: random point sets and random
// consumer backpressure, checked against a pair-enumeration reference model.
module tb_pair_batch_issuer;

  localparam int IW   = 32;
  localparam int CW   = 12;
  localparam int D    = 3;
  localparam int B    = 4;
  localparam int MAXP = 24;
  localparam int CNTW = $clog2(MAXP + 1);

  typedef logic [D-1:0][CW-1:0] pt_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        load_valid;
  pt_t                         load_point;
  logic                        load_ready;
  logic                        clear;
  logic                        start;
  logic [CNTW-1:0]             num_points;
  logic                        busy;
  logic                        done;
  logic                        out_valid;
  logic                        out_ready;
  pt_t                         reference_point;
  logic [IW-1:0]               reference_index;
  logic [B-1:0][D-1:0][CW-1:0] coords;
  logic [B-1:0][IW-1:0]        out_indices;
  logic [B-1:0]                lane_valid;

  pt_t tb_mem [MAXP];
  int  tb_n;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  pc [MAXP][MAXP];

  pair_batch_issuer #(
    .INDEX_BIT_WIDTH (IW),
    .COORD_BIT_WIDTH (CW),
    .DIMENSIONS      (D),
    .BATCH_SIZE      (B),
    .MAX_POINTS      (MAXP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_valid      (load_valid),
    .load_point      (load_point),
    .load_ready      (load_ready),
    .clear           (clear),
    .start           (start),
    .num_points      (num_points),
    .busy            (busy),
    .done            (done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .reference_point (reference_point),
    .reference_index (reference_index),
    .coords          (coords),
    .out_indices     (out_indices),
    .lane_valid      (lane_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic pt_t rnd_pt();
    pt_t p;
    for (int d = 0; d < D; d++) p[d] = CW'($urandom);
    return p;
  endfunction

  // Clear the store and load n fresh random points (called at a negedge).
  task automatic load_set(input int n);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tb_n  = 0;
    check_eq("clr_num", 256'(num_points), 256'(0));
    for (int k = 0; k < n; k++) begin
      pt_t p;
      p = rnd_pt();
      load_valid = 1'b1;
      load_point = p;
      tb_mem[tb_n] = p;
      tb_n++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check_eq("load_num", 256'(num_points), 256'(tb_n));
  endtask

  // Compare the presented beat against the model's beat (u, v).
  task automatic check_beat(input int u, input int v);
    logic [B-1:0]                lv;
    logic [B-1:0][IW-1:0]        ix;
    logic [B-1:0][D-1:0][CW-1:0] cr;
    lv = '0;
    ix = '0;
    cr = '0;
    for (int i = 0; i < B; i++) begin
      if (v + i < tb_n) begin
        lv[i] = 1'b1;
        ix[i] = IW'(v + i);
        cr[i] = tb_mem[v + i];
      end
    end
    check_eq("ref_idx", 256'(reference_index), 256'(u));
    check_eq("ref_pt", 256'(reference_point), 256'(tb_mem[u]));
    check_eq("lane_valid", 256'(lane_valid), 256'(lv));
    check_eq("indices", 256'(out_indices), 256'(ix));
    check_eq("coords", 256'(coords), 256'(cr));
  endtask

  // One enumeration run over the current point set.
  //   rnd      : random out_ready backpressure
  //   ld_start : load one more point in the same cycle as start
  //   noise    : toggle load/start/clear while the run is active
  task automatic do_run(input bit rnd, input bit ld_start, input bit noise);
    int qu[$];
    int qv[$];
    int cyc;
    int bad;
    int lanes;
    for (int a = 0; a < MAXP; a++)
      for (int b = 0; b < MAXP; b++) pc[a][b] = 0;
    start     = 1'b1;
    out_ready = 1'b1;
    if (ld_start) begin
      pt_t p;
      p = rnd_pt();
      load_valid   = 1'b1;
      load_point   = p;
      tb_mem[tb_n] = p;
      tb_n++;
    end
    // Reference: each u sees candidates u+1..N-1 in groups of B.
    for (int u = 0; u < tb_n - 1; u++)
      for (int v = u + 1; v < tb_n; v += B) begin
        qu.push_back(u);
        qv.push_back(v);
      end
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    check_eq("busy_run", 256'(busy), 256'(1));
    cyc = 0;
    while (qu.size() > 0 && cyc < 2000) begin
      check_eq("ov_run", 256'(out_valid), 256'(1));
      check_eq("done_early", 256'(done), 256'(0));
      check_beat(qu[0], qv[0]);
      if (noise) begin
        load_valid = 1'($urandom_range(0, 1));
        load_point = rnd_pt();
        start      = 1'($urandom_range(0, 1));
        clear      = 1'($urandom_range(0, 1));
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_ready && out_valid) begin
        for (int i = 0; i < B; i++) begin
          if (lane_valid[i] && int'(out_indices[i]) < MAXP && int'(reference_index) < MAXP)
            pc[int'(reference_index)][int'(out_indices[i])]++;
        end
        void'(qu.pop_front());
        void'(qv.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    check_eq("beats_left", 256'(qu.size()), 256'(0));
    check_eq("done_pulse", 256'(done), 256'(1));
    check_eq("ov_end", 256'(out_valid), 256'(0));
    @(negedge clk);
    check_eq("done_clr", 256'(done), 256'(0));
    check_eq("busy_end", 256'(busy), 256'(0));
    check_eq("num_kept", 256'(num_points), 256'(tb_n));
    bad   = 0;
    lanes = 0;
    for (int a = 0; a < MAXP; a++)
      for (int b = 0; b < MAXP; b++) begin
        lanes += pc[a][b];
        if ((a < b && b < tb_n && pc[a][b] != 1) || ((a >= b || b >= tb_n) && pc[a][b] != 0)) bad++;
      end
    check_eq("pairs_bad", 256'(bad), 256'(0));
    check_eq("pairs_tot", 256'(lanes), 256'(tb_n * (tb_n - 1) / 2));
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_point = '0;
    clear      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b1;
    tb_n       = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_ov", 256'(out_valid), 256'(0));
    check_eq("rst_done", 256'(done), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_num", 256'(num_points), 256'(0));
    check_eq("rst_lanes", 256'(lane_valid), 256'(0));
    check_eq("rst_coords", 256'(coords), 256'(0));
    check_eq("rst_ldrdy", 256'(load_ready), 256'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Small sets: full and partial batches, then a retained-set re-run.
    load_set(4);  do_run(1'b0, 1'b0, 1'b0);
    load_set(5);  do_run(1'b0, 1'b0, 1'b0);
    do_run(1'b0, 1'b0, 1'b0);
    load_set(3);  do_run(1'b0, 1'b1, 1'b0);
    load_set(2);  do_run(1'b0, 1'b0, 1'b0);
    load_set(1);  do_run(1'b0, 1'b0, 1'b0);
    load_set(0);  do_run(1'b0, 1'b0, 1'b0);

    // Backpressure with a larger set.
    load_set(20); do_run(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a stalled run.
    load_set(10);
    out_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_ov", 256'(out_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    check_eq("arst_ov", 256'(out_valid), 256'(0));
    check_eq("arst_num", 256'(num_points), 256'(0));
    check_eq("arst_busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    tb_n      = 0;
    out_ready = 1'b1;
    @(negedge clk);
    do_run(1'b0, 1'b0, 1'b0);

    // Full store, then ignored inputs during a run.
    load_set(MAXP);
    check_eq("full_ldrdy", 256'(load_ready), 256'(0));
    load_valid = 1'b1;
    load_point = rnd_pt();
    @(negedge clk);
    load_valid = 1'b0;
    check_eq("full_num", 256'(num_points), 256'(MAXP));
    do_run(1'b1, 1'b0, 1'b1);

    // A few random set sizes under random backpressure.
    for (int r = 0; r < 3; r++) begin
      load_set(int'($urandom_range(2, MAXP)));
      do_run(1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
